// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a CPU write to the DMA register halts the CPU, then copies
// one 256-byte page of CPU memory into the PPU through the OAMDATA port.
// Reads fall on even CPU cycles and writes on odd ones. One
// alignment cycle is inserted when the halt cycle lands on an even cycle.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_cycle_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic        mem_read_en,
  output logic        ppu_readWrite,
  output logic        ppu_oamData_EN,
  output logic [7:0]  ppu_data
);

  // The index is 8 bits wide, so the last byte of a transfer is the index wrap.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state, state_n;
  logic        parity, parity_n;
  logic [7:0]  page, page_n;
  logic [7:0]  index, index_n;
  logic [7:0]  byte_q, byte_n;

  // Next-cycle output values. They are decoded from the next state so that
  // every output is a flop and changes only at a CPU cycle boundary.
  logic        halt_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] addr_n;
  logic [7:0]  data_n;

  // Next-state logic, evaluated as if the current CPU cycle ends now.
  always_comb begin
    state_n  = state;
    parity_n = ~parity;
    page_n   = page;
    index_n  = index;
    byte_n   = byte_q;
    case (state)
      S_IDLE: begin
        if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
          page_n  = cpu_wdata;
          index_n = 8'h00;
          state_n = S_HALT;
        end
      end
      // An odd halt cycle means the next cycle is already even, so the read
      // can start at once; otherwise burn one cycle to realign.
      S_HALT:  state_n = parity ? S_READ : S_ALIGN;
      S_ALIGN: state_n = S_READ;
      S_READ: begin
        byte_n  = mem_rdata;
        state_n = S_WRITE;
      end
      S_WRITE: begin
        index_n = index + 8'h01;
        state_n = (index == LAST_IDX) ? S_IDLE : S_READ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode for the cycle that starts after this strobe.
  always_comb begin
    halt_n = (state_n != S_IDLE);
    rd_n   = (state_n == S_READ);
    wr_n   = (state_n == S_WRITE);
    addr_n = rd_n ? {page_n, index_n} : 16'h0000;
    data_n = wr_n ? byte_n : 8'h00;
  end

  // State register; everything advances only on the CPU cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      index  <= 8'h00;
      byte_q <= 8'h00;
    end else if (cpu_cycle_en) begin
      state  <= state_n;
      parity <= parity_n;
      page   <= page_n;
      index  <= index_n;
      byte_q <= byte_n;
    end
  end

  // Registered outputs; reset returns the bus to an idle, non-halting state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_halt       <= 1'b0;
      dma_active     <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_addr       <= 16'h0000;
      ppu_readWrite  <= 1'b1;
      ppu_oamData_EN <= 1'b0;
      ppu_data       <= 8'h00;
    end else if (cpu_cycle_en) begin
      cpu_halt       <= halt_n;
      dma_active     <= halt_n;
      mem_read_en    <= rd_n;
      mem_addr       <= addr_n;
      ppu_readWrite  <= ~wr_n;
      ppu_oamData_EN <= wr_n;
      ppu_data       <= data_n;
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: a memory model feeds DMA reads, a scoreboard
// of expected addresses/bytes is filled when a transfer is triggered and
// drained by a monitor sampling each CPU cycle on the falling clock edge.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_cycle_en = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  mem_rdata;
  logic        cpu_halt, dma_active, mem_read_en;
  logic [15:0] mem_addr;
  logic        ppu_readWrite, ppu_oamData_EN;
  logic [7:0]  ppu_data;

  oam_dma_controller dut (
    .clk(clk), .rst_n(rst_n), .cpu_cycle_en(cpu_cycle_en),
    .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .mem_rdata(mem_rdata), .cpu_halt(cpu_halt), .dma_active(dma_active),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .ppu_readWrite(ppu_readWrite), .ppu_oamData_EN(ppu_oamData_EN),
    .ppu_data(ppu_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tb_cyc;
  int halt_cnt, wr_cnt, first_rd_cyc;
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  // CPU memory contents: page $07 uses the XOR pattern, others a page mix.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    if (hi == 8'h07) return a[7:0] ^ 8'hA5;
    return a[7:0] + {hi[6:0], 1'b0} + hi;
  endfunction

  always_comb mem_rdata = mem_byte(mem_addr);

  // CPU cycle number since reset; bit 0 is the even/odd phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else if (cpu_cycle_en) tb_cyc <= tb_cyc + 1;
  end

  // Monitor: one sample per CPU cycle, just before its closing strobe.
  always @(negedge clk) begin : mon
    logic [15:0] ea;
    logic [7:0]  ed;
    if (rst_n && cpu_cycle_en) begin
      if (cpu_halt === 1'b1) halt_cnt++;
      checks++;
      if (cpu_halt !== dma_active) begin
        errors++;
        $display("FAIL halt_vs_active: cpu_halt=%b dma_active=%b cyc=%0d", cpu_halt, dma_active, tb_cyc);
      end
      if (mem_read_en === 1'b1) begin
        if (first_rd_cyc < 0) first_rd_cyc = tb_cyc;
        checks++;
        if (tb_cyc[0] !== 1'b0) begin
          errors++;
          $display("FAIL read_parity: read on cycle %0d, expected even", tb_cyc);
        end
        checks++;
        if (ppu_oamData_EN !== 1'b0) begin
          errors++;
          $display("FAIL read_write_overlap: oamData_EN=%b during read, expected 0", ppu_oamData_EN);
        end
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: addr %h with empty scoreboard", mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin
            errors++;
            $display("FAIL read_addr: got %h expected %h", mem_addr, ea);
          end
        end
      end
      if (ppu_oamData_EN === 1'b1) begin
        wr_cnt++;
        checks++;
        if (tb_cyc[0] !== 1'b1) begin
          errors++;
          $display("FAIL write_parity: write on cycle %0d, expected odd", tb_cyc);
        end
        checks++;
        if (ppu_readWrite !== 1'b0) begin
          errors++;
          $display("FAIL write_rw: readWrite=%b expected 0", ppu_readWrite);
        end
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: data %h with empty scoreboard", ppu_data);
        end else begin
          ed = exp_data_q.pop_front();
          if (ppu_data !== ed) begin
            errors++;
            $display("FAIL write_data: got %h expected %h", ppu_data, ed);
          end
        end
      end
    end
  end

  // One CPU cycle: 2 clk, strobe on the second.
  task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
    cpu_addr  = a;
    cpu_rw    = rw;
    cpu_wdata = d;
    @(posedge clk); #1;
    cpu_cycle_en = 1'b1;
    @(posedge clk); #1;
    cpu_cycle_en = 1'b0;
    cpu_rw    = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
  endtask

  task automatic push_page(input logic [7:0] p);
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back({p, 8'(i)});
      exp_data_q.push_back(mem_byte({p, 8'(i)}));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({cpu_halt, dma_active, mem_read_en, ppu_oamData_EN} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_ctrl: halt/active/rd/oam=%b expected 0000", tag,
               {cpu_halt, dma_active, mem_read_en, ppu_oamData_EN});
    end
    checks++;
    if (ppu_readWrite !== 1'b1) begin
      errors++;
      $display("FAIL %s_rw: got %b expected 1", tag, ppu_readWrite);
    end
    checks++;
    if (mem_addr !== 16'h0000 || ppu_data !== 8'h00) begin
      errors++;
      $display("FAIL %s_bus: addr=%h data=%h expected 0000/00", tag, mem_addr, ppu_data);
    end
  endtask

  // Full transfer of page p with optional retrigger or stall at a byte count.
  task automatic run_dma(input string name, input logic [7:0] p,
                         input int retrig_at, input int stall_at);
    int trig, exp_halt, exp_gap, budget, changes, hold_wr, halt_end;
    logic [28:0] snap;
    bit retrig_done, stall_done;
    retrig_done = 0;
    stall_done  = 0;
    halt_cnt = 0;
    wr_cnt = 0;
    first_rd_cyc = -1;
    push_page(p);
    trig = tb_cyc;
    // Odd write cycle -> even halt cycle -> alignment cycle needed.
    exp_halt = trig[0] ? 514 : 513;
    exp_gap  = trig[0] ? 3 : 2;
    cyc(16'h4014, 1'b0, p);
    checks++;
    if (cpu_halt !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt_start: cpu_halt=%b expected 1", name, cpu_halt);
    end
    budget = 0;
    while (cpu_halt === 1'b1 && budget < 700) begin
      if (retrig_at >= 0 && wr_cnt == retrig_at && !retrig_done) begin
        retrig_done = 1;
        cyc(16'h4014, 1'b0, 8'h05);
      end else if (stall_at >= 0 && wr_cnt == stall_at && !stall_done) begin
        stall_done = 1;
        changes = 0;
        hold_wr = wr_cnt;
        snap = {cpu_halt, dma_active, mem_addr, mem_read_en, ppu_readWrite, ppu_oamData_EN, ppu_data};
        repeat (50) begin
          @(posedge clk); #1;
          if ({cpu_halt, dma_active, mem_addr, mem_read_en, ppu_readWrite, ppu_oamData_EN, ppu_data} !== snap)
            changes++;
        end
        checks++;
        if (changes != 0 || wr_cnt != hold_wr) begin
          errors++;
          $display("FAIL %s_stall: %0d output changes, writes %0d->%0d, expected none", name, changes, hold_wr, wr_cnt);
        end
      end else begin
        cyc(16'h0000, 1'b1, 8'h00);
      end
      budget++;
    end
    checks++;
    if (budget >= 700) begin
      errors++;
      $display("FAIL %s_timeout: halt still %b after %0d cycles", name, cpu_halt, budget);
    end
    checks++;
    if (dma_active !== 1'b0 || ppu_oamData_EN !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_state: active=%b oam=%b expected 0/0", name, dma_active, ppu_oamData_EN);
    end
    checks++;
    if (halt_cnt != exp_halt) begin
      errors++;
      $display("FAIL %s_halt_len: got %0d cycles expected %0d", name, halt_cnt, exp_halt);
    end
    checks++;
    if (wr_cnt != 256) begin
      errors++;
      $display("FAIL %s_write_count: got %0d expected 256", name, wr_cnt);
    end
    checks++;
    if (first_rd_cyc - trig != exp_gap) begin
      errors++;
      $display("FAIL %s_first_read: gap %0d cycles expected %0d", name, first_rd_cyc - trig, exp_gap);
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d addrs %0d bytes left, expected 0", name, exp_addr_q.size(), exp_data_q.size());
    end
    // No further DMA may start after completion.
    halt_end = halt_cnt;
    repeat (20) cyc(16'h0000, 1'b1, 8'h00);
    checks++;
    if (halt_cnt != halt_end || wr_cnt != 256) begin
      errors++;
      $display("FAIL %s_no_rerun: halt %0d->%0d writes %0d, expected unchanged", name, halt_end, halt_cnt, wr_cnt);
    end
  endtask

  task automatic align_to(input bit odd);
    if (tb_cyc[0] != odd) cyc(16'h0000, 1'b1, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    // A non-DMA write and a DMA-address read must not trigger anything.
    cyc(16'h4015, 1'b0, 8'h12);
    cyc(16'h4014, 1'b1, 8'h00);
    checks++;
    if (cpu_halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_false_trigger: cpu_halt=%b expected 0", cpu_halt);
    end
  endtask

  task automatic test_even_alignment();
    cyc(16'h0000, 1'b1, 8'h00);
    cyc(16'h0000, 1'b1, 8'h00);
    align_to(1'b1);
    run_dma("even", 8'h02, -1, -1);
  endtask

  task automatic test_odd_alignment();
    align_to(1'b0);
    run_dma("odd", 8'h04, -1, -1);
  endtask

  task automatic test_data_integrity();
    align_to(1'b1);
    run_dma("xor_page7", 8'h07, -1, -1);
  endtask

  task automatic test_retrigger();
    run_dma("retrigger", 8'h03, 100, -1);
  endtask

  task automatic test_reset_mid();
    int budget;
    wr_cnt = 0;
    push_page(8'h06);
    cyc(16'h4014, 1'b0, 8'h06);
    budget = 0;
    while (wr_cnt < 37 && budget < 200) begin
      cyc(16'h0000, 1'b1, 8'h00);
      budget++;
    end
    checks++;
    if (wr_cnt != 37) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d writes expected 37", wr_cnt);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(16'h0000, 1'b1, 8'h00);
    run_dma("after_reset", 8'h01, -1, -1);
  endtask

  task automatic test_stall();
    run_dma("stall_pageff", 8'hFF, -1, 128);
  endtask

  initial begin
    halt_cnt = 0;
    wr_cnt = 0;
    first_rd_cyc = -1;
    test_reset();
    test_even_alignment();
    test_odd_alignment();
    test_data_integrity();
    test_retrigger();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Implements the $4014 OAM DMA engine on the CPU side of the PPU register interface.
- On a CPU write of page value P to $4014, it halts the CPU and reads 256 bytes from CPU memory $PP00-$PPFF.
- Each byte is written into the PPU through the OAMDATA ($2004) register port, using the same readWrite/oamData_EN/data signalling a CPU store would use.
- It sits between the CPU bus and the PPU register block, and muxes in as bus master while active.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- XFER_LEN, 256, bytes per transfer; fixed at 256. Index counter is 8 bits and its wrap terminates the transfer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_cycle_en  in  1  one-clk strobe marking the end of each CPU cycle; all state advances only on this strobe
- cpu_addr  in  16  CPU address bus
- cpu_rw  in  1  CPU bus direction, 1=read, 0=write
- cpu_wdata  in  8  CPU write data
- mem_rdata  in  8  CPU-memory read data, valid at cpu_cycle_en of a read cycle
- cpu_halt  out  1  holds CPU off the bus (RDY low)
- dma_active  out  1  high from the halt cycle through the last write cycle
- mem_addr  out  16  DMA read address {page, index}
- mem_read_en  out  1  DMA memory read this CPU cycle
- ppu_readWrite  out  1  to PPU register block, 0 = write, 1 = idle/read
- ppu_oamData_EN  out  1  OAMDATA select to PPU register block
- ppu_data  out  8  byte driven to PPU cpuData_IN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, parity=0, index=0, page=0, latched byte=0.
  - Outputs: cpu_halt=0, dma_active=0, mem_read_en=0, ppu_oamData_EN=0, ppu_readWrite=1, ppu_data=0, mem_addr=0.
  - Reset mid-transfer aborts immediately; the partial OAM contents are left as written.
- Parity bit toggles on every cpu_cycle_en. Parity 0 = even ("get") cycle, parity 1 = odd ("put") cycle.
- Trigger: in IDLE, at a cpu_cycle_en with cpu_rw=0 and cpu_addr==DMA_REG_ADDR:
  - page <= cpu_wdata, index <= 0, state -> HALT.
  - Writes to DMA_REG_ADDR while not IDLE are ignored.
- States and transitions (each advance occurs on cpu_cycle_en):
  - IDLE: all outputs inactive.
  - HALT: cpu_halt=1, dma_active=1. Next state is READ if the current parity=1, else ALIGN.
  - ALIGN: one dummy cycle with no bus activity. Next state is READ.
  - READ: mem_read_en=1, mem_addr={page,index}. At cpu_cycle_en, latch mem_rdata; next state is WRITE.
  - WRITE: ppu_readWrite=0, ppu_oamData_EN=1, ppu_data=latched byte. At cpu_cycle_en:
    - index <= index+1.
    - If index was 8'hFF, state -> IDLE; otherwise -> READ.
- READ always falls on even cycles and WRITE on odd cycles.
- Total halt duration: 513 CPU cycles if the HALT cycle is odd, 514 if it is even. The $4014 write cycle itself is not counted.
- ppu_oamData_EN is held for the entire WRITE CPU cycle and deasserts at the next cpu_cycle_en. The PPU-side OAM address increment therefore sees exactly one falling edge per byte.
- cpu_halt and dma_active are registered and change only at cpu_cycle_en (or on reset). Both deassert in the clk following the final WRITE strobe.
- Outputs are registered; no combinational path from cpu_* inputs to outputs.
- Page 8'hFF is legal: addresses $FF00-$FFFF, with index wrap ending the transfer.
- cpu_cycle_en held low freezes all state indefinitely.

Test Plan:
- Even alignment: reset, run 2 cycles, write $02 to $4014 on an odd cycle → HALT lands even → ALIGN → first READ addr $0200; 514 halted cycles; 256 ppu_oamData_EN pulses carrying mem bytes $0200-$02FF in order.
- Odd alignment: trigger so HALT lands odd → no ALIGN, first READ the next cycle; cpu_halt high exactly 513 cycles.
- Data integrity: memory model returns addr[7:0]^8'hA5 for page $07 → PPU-side scoreboard receives 256 bytes matching; 256 writes with ppu_readWrite=0, no read-enable overlap with oamData_EN.
- Retrigger ignored: write $05 to $4014 at byte 100 of a page-$03 transfer → transfer continues on $03xx, completes normally, no second DMA.
- Reset mid-op: assert rst_n=0 at byte 37 → all outputs at reset values within the same clk, cpu_halt=0; a later $4014 write of $01 starts a clean transfer from $0100.
- Clock-enable stall: hold cpu_cycle_en low for 50 clk mid-transfer → outputs stable, no extra pulses; resuming completes with exactly 256 writes; page $FF reads $FF00-$FFFF and terminates.
